// File: rtl/muxpga_cfg_sequencer.sv
// Job sequencer for the 5x3 mux-FPGA fabric: streams config nibbles, clocks the fabric, captures io_out.
// Optional build macro MUXPGA_SEQ_READBACK_EN adds the readback_xor chain-tail checksum output.
module muxpga_cfg_sequencer #(
   parameter int NUM_NIBBLES = 24,
   parameter int RUN_W       = 8,
   parameter int TIMEOUT     = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             do_load,
   input  logic [RUN_W-1:0] run_cycles,
   input  logic             cfg_valid,
   input  logic [3:0]       cfg_nibble,
   output logic             cfg_ready,
   input  logic [3:0]       data_in,
   output logic [3:0]       fpga_nibble,
   output logic [1:0]       fpga_cmd,
   input  logic [7:0]       fpga_out,
   output logic [7:0]       result,
   output logic             result_valid,
   output logic             busy,
   output logic             error
`ifdef MUXPGA_SEQ_READBACK_EN
   ,
   output logic [3:0]       readback_xor
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;

   localparam logic [1:0] CMD_SHIFT = 2'd0;
   localparam logic [1:0] CMD_RUN   = 2'd1;
   localparam logic [1:0] CMD_HOLD  = 2'd2;

   localparam logic [4:0] NIB_LAST     = 5'(NUM_NIBBLES - 1);
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]       state_q, state_d;
   logic [1:0]       cmd_q, cmd_d;
   logic [3:0]       nib_q, nib_d;
   logic             ready_q, ready_d;
   logic [7:0]       result_q, result_d;
   logic             rv_q, rv_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic [4:0]       nib_cnt_q, nib_cnt_d;
   logic [7:0]       idle_cnt_q, idle_cnt_d;
   logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
   logic [RUN_W-1:0] run_len_q, run_len_d;
   logic             accept_s;

   assign accept_s = (state_q == S_LOAD) && ready_q && cfg_valid;

   // Next-state and registered-output computation for the job FSM.
   always_comb begin
      state_d    = state_q;
      cmd_d      = CMD_HOLD;
      nib_d      = 4'd0;
      ready_d    = 1'b0;
      result_d   = result_q;
      rv_d       = 1'b0;
      err_d      = 1'b0;
      nib_cnt_d  = nib_cnt_q;
      idle_cnt_d = idle_cnt_q;
      run_cnt_d  = run_cnt_q;
      run_len_d  = run_len_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               run_len_d  = run_cycles;
               run_cnt_d  = '0;
               nib_cnt_d  = 5'd0;
               idle_cnt_d = 8'd0;
               if (do_load) begin
                  state_d = S_LOAD;
                  ready_d = 1'b1;
               end else begin
                  state_d = S_RUN;
                  cmd_d   = CMD_RUN;
                  nib_d   = data_in;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (accept_s) begin
               cmd_d      = CMD_SHIFT;
               nib_d      = cfg_nibble;
               idle_cnt_d = 8'd0;
               nib_cnt_d  = nib_cnt_q + 5'd1;
               // Saturating compare: the last accept leaves LOAD, so the count never wraps.
               if (nib_cnt_q >= NIB_LAST) begin
                  state_d = S_RUN;
                  ready_d = 1'b0;
               end else begin
                  ready_d = 1'b1;
               end
            end else if (idle_cnt_q >= TIMEOUT_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               idle_cnt_d = idle_cnt_q + 8'd1;
               ready_d    = 1'b1;
            end
         end
         S_RUN: begin
            nib_d = data_in;
            // First RUN cycle after a load still carries the final shift on the pins.
            if (cmd_q != CMD_RUN) begin
               cmd_d = CMD_RUN;
            end else if (run_cnt_q == run_len_q) begin
               result_d = fpga_out;
               rv_d     = 1'b1;
               state_d  = S_IDLE;
               cmd_d    = CMD_HOLD;
               nib_d    = 4'd0;
            end else begin
               cmd_d     = CMD_RUN;
               run_cnt_d = run_cnt_q + RUN_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cmd_q      <= CMD_HOLD;
         nib_q      <= 4'd0;
         ready_q    <= 1'b0;
         result_q   <= 8'd0;
         rv_q       <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         nib_cnt_q  <= 5'd0;
         idle_cnt_q <= 8'd0;
         run_cnt_q  <= '0;
         run_len_q  <= '0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         nib_q      <= nib_d;
         ready_q    <= ready_d;
         result_q   <= result_d;
         rv_q       <= rv_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         nib_cnt_q  <= nib_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         run_cnt_q  <= run_cnt_d;
         run_len_q  <= run_len_d;
      end
   end

   assign fpga_cmd     = cmd_q;
   assign fpga_nibble  = nib_q;
   assign cfg_ready    = ready_q;
   assign result       = result_q;
   assign result_valid = rv_q;
   assign busy         = busy_q;
   assign error        = err_q;

`ifdef MUXPGA_SEQ_READBACK_EN
   logic [3:0] rb_q, rb_d;

   // Checksum of the chain tail seen while shifting; cleared when a load begins.
   always_comb begin
      rb_d = rb_q;
      if ((state_q == S_IDLE) && start && do_load) begin
         rb_d = 4'd0;
      end else if (cmd_q == CMD_SHIFT) begin
         rb_d = rb_q ^ fpga_out[7:4];
      end else begin
         rb_d = rb_q;
      end
   end

   // Readback checksum register.
   always_ff @(posedge clk) begin
      if (reset) begin
         rb_q <= 4'd0;
      end else begin
         rb_q <= rb_d;
      end
   end

   assign readback_xor = rb_q;
`endif

endmodule
